button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a level change; legal range >= 2.
REQ-002 SHALL provide parameter ACTIVE_LOW, default 1: 1 means i_btn low = pressed; 0 means i_btn high = pressed.
REQ-003 SHALL have port i_clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_btn  input  1  raw asynchronous button/reset-switch contact, may bounce.
REQ-006 SHALL have port o_level  output  1  debounced pressed state, 1 = pressed; feeds the downstream reset synchronizer.
REQ-007 SHALL have port o_press  output  1  one-cycle pulse on accepted released->pressed change.
REQ-008 SHALL have port o_release  output  1  one-cycle pulse on accepted pressed->released change.
REQ-009 SHALL have port o_busy  output  1  high while a candidate change is being counted.

Function
REQ-010 SHALL pass i_btn through a 2-flop synchronizer (s1, s2); the polarity-corrected value of s2 is "sample" (1 = pressed).
REQ-011 SHALL implement a 4-state FSM: REL (stable released), REL_CHK (counting toward press), PRS (stable pressed), PRS_CHK (counting toward release).
REQ-012 SHALL hold a counter of width ceil(log2(DEBOUNCE_CYCLES))+1 bits, unsigned, never wrapping.
REQ-013 In REL or PRS with sample == o_level: SHALL stay, counter = 0.
REQ-014 In REL/PRS with sample != o_level: SHALL go to REL_CHK/PRS_CHK, counter = 1.
REQ-015 In a CHK state with sample == o_level (bounce back): SHALL return to REL/PRS, counter = 0, no pulse.
REQ-016 In a CHK state with sample != o_level and counter < DEBOUNCE_CYCLES-1: SHALL increment counter and stay.
REQ-017 In a CHK state with sample != o_level and counter == DEBOUNCE_CYCLES-1: SHALL toggle o_level, go to PRS (from REL_CHK) or REL (from PRS_CHK), clear counter, and assert o_press or o_release for that cycle only.
REQ-018 Latency: with i_btn stable after a change first captured in s1 at edge k, o_level and the pulse SHALL update at edge k+DEBOUNCE_CYCLES+1.
REQ-019 o_press and o_release SHALL be registered, mutually exclusive, and never high for 2 consecutive cycles.
REQ-020 o_busy SHALL be registered and equal 1 exactly when the state is REL_CHK or PRS_CHK.
REQ-021 Any single-cycle glitch of sample back to o_level during counting SHALL restart the full DEBOUNCE_CYCLES window.

Reset
REQ-022 i_rst_n low SHALL immediately, without a clock edge, force: s1/s2 = released value, state REL, counter 0, o_level 0, o_press 0, o_release 0, o_busy 0.
REQ-023 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted on reset assertion or deassertion.
REQ-024 After deassertion with the button held, a press SHALL be accepted only through the normal path (REQ-018), counting from the first post-reset capture edge.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1 unless stated)
REQ-025 Clean press: i_btn 1->0 captured at edge k -> o_level 0->1 and o_press=1 at edge k+5; o_press=0 at k+6; o_busy high k+2..k+4.
REQ-026 Bounce: i_btn low 2 cycles, high 1, then low stable (last fall captured at edge j) -> no pulse before edge j+5; o_level=1 and a single o_press at edge j+5.
REQ-027 Release: from pressed, i_btn 0->1 captured at edge k -> o_level=0 and o_release=1 at edge k+5; o_press stays 0.
REQ-028 Reset mid-count: i_rst_n low while in REL_CHK, counter=2 -> o_level/o_busy/pulses 0 asynchronously; i_btn held low, i_rst_n released before edge 1 -> o_press at edge 6 after deassertion, no other pulse.
REQ-029 Polarity: ACTIVE_LOW=0, i_btn 0->1 captured at edge k -> o_level=1 and o_press at edge k+5.

Source files
------------

// File: rtl/button_debounce.sv
// Debounces a raw, possibly bouncing button contact into a clean pressed level.
// Ports: i_clk, i_rst_n (async low), i_btn raw; o_level, o_press, o_release, o_busy.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic REL_RAW = ACTIVE_LOW;

  typedef enum logic [1:0] {
    REL,
    REL_CHK,
    PRS,
    PRS_CHK
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic level_n, press_n, release_n, busy_n;
  logic s1, s2, sample;

  // The synchronizer rests at the raw released level so that
  // reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= REL_RAW;
      s2 <= REL_RAW;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
    end
  end

  assign sample = s2 ^ REL_RAW;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = o_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    unique case (state)
      REL, PRS: begin
        if (sample != o_level) begin
          state_n = (state == REL) ? REL_CHK : PRS_CHK;
          cnt_n   = CW'(1);
        end else begin
          cnt_n = '0;
        end
      end
      REL_CHK, PRS_CHK: begin
        if (sample == o_level) begin
          // Bounced back: drop the candidate, restart the window later.
          state_n = (state == REL_CHK) ? REL : PRS;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n   = (state == REL_CHK) ? PRS : REL;
          cnt_n     = '0;
          level_n   = ~o_level;
          press_n   = (state == REL_CHK);
          release_n = (state == PRS_CHK);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = REL;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n == REL_CHK) || (state_n == PRS_CHK);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= REL;
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      o_level   <= level_n;
      o_press   <= press_n;
      o_release <= release_n;
      o_busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: active-low and active-high instances.
// Stimulus queues expected pulses and level/busy probes; monitors compare.
module tb_button_debounce;

  logic clk;
  logic rst_n;
  logic btn;
  logic btn2;
  logic [1:0] lvl, prs, rls, bsy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int d;
    bit rel;
  } pulse_t;

  typedef struct {
    int   cyc;
    int   d;
    logic lvl;
    logic bsy;
  } probe_t;

  pulse_t pq[$];
  probe_t rq[$];

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut_lo (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_btn(btn),
    .o_level(lvl[0]),
    .o_press(prs[0]),
    .o_release(rls[0]),
    .o_busy(bsy[0])
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(0)
  ) dut_hi (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_btn(btn2),
    .o_level(lvl[1]),
    .o_press(prs[1]),
    .o_release(rls[1]),
    .o_busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic probe(input int c, input int d,
                       input logic l, input logic b);
    probe_t p;
    p.cyc = c;
    p.d   = d;
    p.lvl = l;
    p.bsy = b;
    rq.push_back(p);
  endtask

  task automatic pulse(input int c, input int d, input bit r);
    pulse_t p;
    p.cyc = c;
    p.d   = d;
    p.rel = r;
    pq.push_back(p);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulse and probe monitor, sampling on the falling edge.
  initial begin
    pulse_t e;
    probe_t p;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (prs[d] || rls[d]) begin
          checks++;
          if (pq.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected dut%0d cyc %0d press %b release %b, required none",
                     d, cyc, prs[d], rls[d]);
          end else begin
            e = pq.pop_front();
            if (e.cyc != cyc || e.d != d || prs[d] != !e.rel || rls[d] != e.rel) begin
              errors++;
              $display("FAIL pulse dut%0d cyc %0d press %b release %b, required dut%0d cyc %0d rel %b",
                       d, cyc, prs[d], rls[d], e.d, e.cyc, e.rel);
            end
          end
        end
      end
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        e = pq.pop_front();
        checks++;
        errors++;
        $display("FAIL pulse_missing dut%0d required at cyc %0d rel %b, no pulse observed",
                 e.d, e.cyc, e.rel);
      end
      while (rq.size() > 0 && rq[0].cyc <= cyc) begin
        p = rq.pop_front();
        checks++;
        if (p.cyc != cyc || lvl[p.d] !== p.lvl || bsy[p.d] !== p.bsy) begin
          errors++;
          $display("FAIL probe dut%0d cyc %0d level %b busy %b, required cyc %0d level %b busy %b",
                   p.d, cyc, lvl[p.d], bsy[p.d], p.cyc, p.lvl, p.bsy);
        end
      end
    end
  end

  // Reset must clear outputs without waiting for a clock edge.
  initial begin
    forever begin
      @(negedge rst_n);
      #1;
      checks++;
      if (lvl !== 2'b00 || prs !== 2'b00 || rls !== 2'b00 || bsy !== 2'b00) begin
        errors++;
        $display("FAIL reset_async level %b press %b release %b busy %b, required all 0",
                 lvl, prs, rls, bsy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, k, j, r;
    rst_n = 1'b1;
    btn   = 1'b1;
    btn2  = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    probe(c + 1, 0, 1'b0, 1'b0);
    probe(c + 2, 0, 1'b0, 1'b0);
    probe(c + 2, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Clean press
    c = cyc;
    btn = 1'b0;
    k = c + 1;
    probe(k + 1, 0, 1'b0, 1'b0);
    probe(k + 2, 0, 1'b0, 1'b1);
    probe(k + 4, 0, 1'b0, 1'b1);
    probe(k + 5, 0, 1'b1, 1'b0);
    probe(k + 6, 0, 1'b1, 1'b0);
    pulse(k + 5, 0, 1'b0);
    wait_cyc(k + 8);

    // Clean release
    c = cyc;
    btn = 1'b1;
    k = c + 1;
    probe(k + 4, 0, 1'b1, 1'b1);
    probe(k + 5, 0, 1'b0, 1'b0);
    pulse(k + 5, 0, 1'b1);
    wait_cyc(k + 8);

    // Bounce: low 2, high 1, low stable
    c = cyc;
    btn = 1'b0;
    probe(c + 3, 0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    j = c + 4;
    probe(j + 1, 0, 1'b0, 1'b0);
    probe(j + 4, 0, 1'b0, 1'b1);
    probe(j + 5, 0, 1'b1, 1'b0);
    pulse(j + 5, 0, 1'b0);
    wait_cyc(j + 8);

    // Release back to idle
    c = cyc;
    btn = 1'b1;
    pulse(c + 6, 0, 1'b1);
    wait_cyc(c + 9);

    // Reset while counting toward a press, button held
    c = cyc;
    btn = 1'b0;
    k = c + 1;
    probe(k + 3, 0, 1'b0, 1'b1);
    wait_cyc(k + 3);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    probe(r + 1, 0, 1'b0, 1'b0);
    probe(r + 5, 0, 1'b0, 1'b1);
    probe(r + 6, 0, 1'b1, 1'b0);
    pulse(r + 6, 0, 1'b0);
    wait_cyc(r + 9);

    // Active-high instance: press then release
    c = cyc;
    btn2 = 1'b1;
    k = c + 1;
    probe(k + 4, 1, 1'b0, 1'b1);
    probe(k + 5, 1, 1'b1, 1'b0);
    pulse(k + 5, 1, 1'b0);
    wait_cyc(k + 8);
    c = cyc;
    btn2 = 1'b0;
    probe(c + 6, 1, 1'b0, 1'b0);
    pulse(c + 6, 1, 1'b1);
    wait_cyc(c + 9);

    repeat (3) @(negedge clk);
    checks++;
    if (pq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained pulses %0d probes %0d, required 0 0",
               pq.size(), rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
